// File: rtl/pkt_bufid_dispatcher_pkg.sv
// rtl/pkt_bufid_dispatcher_pkg.sv - shared constants and dispatch state encoding
package pkt_bufid_dispatcher_pkg;

  localparam int DEF_BUFID_W  = 9;
  localparam int RDUSEDW_W    = 9;
  localparam int PORT_NUM_MIN = 2;
  localparam int PORT_NUM_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_STARVED = 2'b10,
    ST_RETURN  = 2'b11
  } dispatch_state_e;

endpackage

// File: rtl/pkt_bufid_dispatcher_if.sv
// rtl/pkt_bufid_dispatcher_if.sv - free-FIFO and per-port bufid handshake bundle
interface pkt_bufid_dispatcher_if #(
  parameter int PORT_NUM = 4,
  parameter int BUFID_W  = pkt_bufid_dispatcher_pkg::DEF_BUFID_W
) ();
  import pkt_bufid_dispatcher_pkg::*;

  // free-bufid FIFO side
  logic [BUFID_W-1:0]          iv_free_bufid;
  logic                        i_free_bufid_empty;
  logic [RDUSEDW_W-1:0]        iv_free_bufid_fifo_rdusedw;
  logic                        o_free_bufid_rd;
  logic                        o_bufid_return_wr;
  logic [BUFID_W-1:0]          ov_bufid_return;

  // per-port side
  logic [PORT_NUM-1:0]         iv_port_enable;
  logic [PORT_NUM-1:0]         o_pkt_bufid_wr;
  logic [PORT_NUM*BUFID_W-1:0] ov_pkt_bufid;
  logic [PORT_NUM-1:0]         iv_pkt_bufid_ack;

  // status
  logic                        o_starve_pulse;
  logic                        o_ack_err_pulse;
  logic [1:0]                  ov_dispatch_state;

  modport master (
    input  iv_free_bufid, i_free_bufid_empty, iv_free_bufid_fifo_rdusedw,
    input  iv_port_enable, iv_pkt_bufid_ack,
    output o_free_bufid_rd, o_bufid_return_wr, ov_bufid_return,
    output o_pkt_bufid_wr, ov_pkt_bufid,
    output o_starve_pulse, o_ack_err_pulse, ov_dispatch_state
  );

  modport slave (
    output iv_free_bufid, i_free_bufid_empty, iv_free_bufid_fifo_rdusedw,
    output iv_port_enable, iv_pkt_bufid_ack,
    input  o_free_bufid_rd, o_bufid_return_wr, ov_bufid_return,
    input  o_pkt_bufid_wr, ov_pkt_bufid,
    input  o_starve_pulse, o_ack_err_pulse, ov_dispatch_state
  );

endinterface

// File: rtl/pkt_bufid_dispatcher_rr_priority_picker.sv
// rtl/pkt_bufid_dispatcher_rr_priority_picker.sv - round-robin first-requester picker
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan upward from ptr with wrap-around; the first requester found wins.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/pkt_bufid_dispatcher.sv
// rtl/pkt_bufid_dispatcher.sv - hands free bufids to input ports round-robin, returns them on disable
module pkt_bufid_dispatcher #(
  parameter int         PORT_NUM    = 4,
  parameter int         BUFID_W     = pkt_bufid_dispatcher_pkg::DEF_BUFID_W,
  parameter logic [8:0] RESERVE_NUM = 9'd0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  pkt_bufid_dispatcher_if.master bus
);
  import pkt_bufid_dispatcher_pkg::*;

  localparam int PW = $clog2(PORT_NUM);

  if (PORT_NUM < PORT_NUM_MIN || PORT_NUM > PORT_NUM_MAX) begin : g_bad_port_num
    $error("pkt_bufid_dispatcher: PORT_NUM out of range");
  end

  logic [PORT_NUM-1:0] offered_q;
  logic [BUFID_W-1:0]  bufid_q [PORT_NUM];
  logic [PW-1:0]       ptr_q;
  dispatch_state_e     state_q, state_d;

  logic [PORT_NUM-1:0] ack_ok, need, ret_req, ret_oh, grant_oh, offered_d;
  logic [PW-1:0]       grant_idx, ret_idx;
  logic                any_need, any_ret, fifo_ok, do_grant, starve;

  // An acking port is still offered this cycle, so it never shows up in need.
  assign ack_ok   = bus.iv_pkt_bufid_ack & offered_q;
  assign need     = bus.iv_port_enable & ~offered_q;
  assign ret_req  = offered_q & ~bus.iv_port_enable & ~bus.iv_pkt_bufid_ack;
  assign any_ret  = |ret_req;
  assign fifo_ok  = ~bus.i_free_bufid_empty &&
                    (bus.iv_free_bufid_fifo_rdusedw > RESERVE_NUM);
  assign do_grant = any_need & fifo_ok & ~any_ret;
  assign starve   = any_need & ~fifo_ok;

  rr_priority_picker #(.N(PORT_NUM), .PW(PW)) u_picker (
    .req       (need),
    .ptr       (ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_need)
  );

  // Lowest-index disabled port with an unconsumed bufid is returned first.
  always_comb begin
    ret_oh  = '0;
    ret_idx = '0;
    for (int p = PORT_NUM - 1; p >= 0; p--) begin
      if (ret_req[p]) begin
        ret_oh    = '0;
        ret_oh[p] = 1'b1;
        ret_idx   = PW'(p);
      end
    end
  end

  // Next offered vector: acks clear, then either one return clears or one grant sets.
  always_comb begin
    offered_d = offered_q & ~ack_ok;
    if (any_ret) begin
      offered_d = offered_d & ~ret_oh;
    end else if (do_grant) begin
      offered_d = offered_d | grant_oh;
    end
  end

  // Status reported next cycle, most significant decision first.
  always_comb begin
    state_d = ST_IDLE;
    if (any_ret) begin
      state_d = ST_RETURN;
    end else if (do_grant) begin
      state_d = ST_GRANT;
    end else if (starve) begin
      state_d = ST_STARVED;
    end
  end

  // Offer flags, round-robin pointer and status register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      offered_q <= '0;
      ptr_q     <= '0;
      state_q   <= ST_IDLE;
    end else begin
      offered_q <= offered_d;
      state_q   <= state_d;
      if (do_grant) begin
        ptr_q <= (grant_idx == PW'(PORT_NUM - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  // Capture the FIFO head into the granted port's holding register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        bufid_q[p] <= '0;
      end
    end else if (do_grant) begin
      bufid_q[grant_idx] <= bus.iv_free_bufid;
    end
  end

  // Pulses are held low during reset so the FIFO is not touched then.
  assign bus.o_free_bufid_rd   = reset_n & do_grant;
  assign bus.o_bufid_return_wr = reset_n & any_ret;
  assign bus.ov_bufid_return   = (reset_n & any_ret) ? bufid_q[ret_idx] : '0;
  assign bus.o_starve_pulse    = reset_n & starve;
  assign bus.o_ack_err_pulse   = reset_n & (|(bus.iv_pkt_bufid_ack & ~offered_q));
  assign bus.o_pkt_bufid_wr    = offered_q;
  assign bus.ov_dispatch_state = state_q;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port_out
    assign bus.ov_pkt_bufid[p*BUFID_W +: BUFID_W] = bufid_q[p];
  end

endmodule

// File: doc/pkt_bufid_dispatcher.md
Name: pkt_bufid_dispatcher

Overview:
Distributes free packet-buffer IDs from the shared free-bufid FIFO to PORT_NUM network_input_process instances over their i_pkt_bufid_wr / iv_pkt_bufid / o_pkt_bufid_ack interface. Keeps at most one pre-fetched bufid offered per port, chosen round-robin, and honours a reserve floor on the FIFO. When a port is disabled, any bufid it has not yet consumed goes back to the free FIFO. Sits in the clk_sys domain between the buffer manager's free-bufid FIFO and the per-port input pipelines.

Parameters:
PORT_NUM, 4, number of input ports served (2..8)
BUFID_W, 9, bufid width
RESERVE_NUM, 9'd0, minimum FIFO occupancy that must stay in the FIFO; allocation only when rdusedw > RESERVE_NUM

Ports:
clk_sys  in  1  system clock; the only clock
reset_n  in  1  synchronous reset, active-low
iv_free_bufid  in  BUFID_W  head of free-bufid FIFO (show-ahead)
i_free_bufid_empty  in  1  free FIFO empty
iv_free_bufid_fifo_rdusedw  in  9  free FIFO occupancy
o_free_bufid_rd  out  1  pop free FIFO (one-cycle pulse)
o_bufid_return_wr  out  1  write returned bufid into free FIFO
ov_bufid_return  out  BUFID_W  returned bufid
iv_port_enable  in  PORT_NUM  per-port enable (from configuration)
o_pkt_bufid_wr  out  PORT_NUM  per-port bufid offer valid
ov_pkt_bufid  out  PORT_NUM*BUFID_W  per-port bufid, port p at [p*BUFID_W +: BUFID_W]
iv_pkt_bufid_ack  in  PORT_NUM  per-port consume acknowledge
o_starve_pulse  out  1  a port needed a bufid but allocation was blocked this cycle
o_ack_err_pulse  out  1  ack received on a port with no offer outstanding
ov_dispatch_state  out  2  00 IDLE, 01 GRANT, 10 STARVED, 11 RETURN

Behaviour:
- Reset (reset_n low at a clk_sys edge): all outputs 0; offered[] cleared; RR pointer = 0; ov_pkt_bufid = 0; ov_dispatch_state = IDLE. Bufids held at reset are discarded; the buffer manager resets the free FIFO in the same reset.
- Per-port holding register: offered[p] and bufid[p]. o_pkt_bufid_wr[p] = offered[p], registered. The bufid is stable while offered.
- Consume: iv_pkt_bufid_ack[p] high while offered[p] -> offered[p] cleared at that edge, so wr is low the following cycle. Ack with offered[p] = 0 -> ignored, o_ack_err_pulse for 1 cycle.
- Need vector: need[p] = iv_port_enable[p] & ~offered[p]. A port acking this cycle does not count as needing, so it cannot be re-granted in the same cycle.
- Allocation (at most one per cycle):
  - Condition: any need, ~i_free_bufid_empty, rdusedw > RESERVE_NUM, and no return in progress this cycle.
  - Grant g = first needing port searching upward from the RR pointer, with wrap-around.
  - Cycle T: o_free_bufid_rd = 1 (combinational from registered state), bufid[g] <= iv_free_bufid, offered[g] <= 1, pointer <= g+1 mod PORT_NUM.
  - o_pkt_bufid_wr[g] is high from T+1. Latency from need to offer is 1 cycle.
- Starvation: need present but FIFO empty or rdusedw <= RESERVE_NUM -> no pop, o_starve_pulse = 1, state STARVED. Pointer is unchanged.
- Return:
  - Trigger: offered[p] & ~iv_port_enable[p] & ~iv_pkt_bufid_ack[p].
  - Action: o_bufid_return_wr = 1, ov_bufid_return = bufid[p], offered[p] cleared.
  - Ordering: one return per cycle, lowest index first. Return has priority over allocation, so no pop happens that cycle.
  - Ack and disable in the same cycle count as a consume; no return is made.
- Simultaneous events: acks on several ports in one cycle are all processed. One allocation or one return proceeds alongside them.
- ov_dispatch_state is registered, reflecting the decision of the previous cycle: RETURN > GRANT > STARVED > IDLE.
- iv_port_enable low with offered[p] = 0 -> port is skipped by arbitration.

Decomposition:
- Shared package pkt_bufid_dispatcher_pkg: BUFID_W, dispatch state encodings (IDLE/GRANT/STARVED/RETURN), PORT_NUM limit.
- One sub-module: rr_priority_picker. Inputs: request vector and pointer. Outputs: one-hot grant, grant index, any-grant. Purely combinational.
- The rest (holding registers, return priority encoder, FSM status) stays in the top module.

Test Plan:
- Basic fill: FIFO holds bufids 5,6,7,8, all 4 ports enabled, no acks -> ports 0,1,2,3 offered 5,6,7,8 on consecutive cycles; 4 rd pulses; state GRANT then IDLE.
- Consume/refill round-robin: after fill, ack port 2 at cycle T with FIFO head 9 -> wr[2] low at T+1, port 2 offered 9 from T+2, pointer = 3.
- Reserve/starve: RESERVE_NUM = 2, rdusedw = 2, port 0 needing -> no rd, o_starve_pulse each cycle, state STARVED. rdusedw goes to 3 -> port 0 granted next cycle.
- Disable return: port 1 offered bufid 0x1A3, iv_port_enable[1] drops -> o_bufid_return_wr = 1 with 0x1A3 for 1 cycle, no rd that cycle, wr[1] low. Repeat with ack in the same cycle as the disable -> no return.
- Ack error and simultaneous acks: ack port 3 while not offered -> o_ack_err_pulse = 1, state unaffected. Acks on ports 0 and 2 in the same cycle -> both cleared, refilled in RR order 0 then 2 over the next 2 cycles.
- Reset mid-operation: reset_n low for 1 cycle while 3 ports are offered -> all wr/rd/return outputs 0 and pointer 0 next cycle; after reset, refill starts at port 0.
